obstacle_bank: RTL

Parametrised bank of NUM_OBS independently moving obstacles for the game layer, replacing per-instance single-obstacle movers. Each frame_clk edge advances every active obstacle by its own signed step under a per-obstacle motion mode, and optionally checks overlap against the player box. It sits between the game-control logic, which loads obstacles over a valid/ready port, and the color mapper, which reads the flattened position vectors.

---
 rtl/obstacle_bank.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/obstacle_bank.sv
// obstacle_bank: bank of NUM_OBS independently moving obstacles with a config port and player overlap detection
// Ports:
//   frame_clk, Reset_n                      one edge per video frame; asynchronous active-low reset
//   freeze                                  holds all motion; config writes still land
//   cfg_valid/cfg_ready, cfg_idx..cfg_dy    per-obstacle load (one write per two edges)
//   player_x/_y/_size                       player box for overlap tests
//   obs_x/obs_y/obs_active, OBS_size        flattened centres (obstacle i at [10i+9:10i]), active flags, half-width
//   hit_vec/hit_pulse/hit_idx               overlap set, new-overlap pulse, lowest new index
// Optional feature: define OBSTACLE_COLLIDE_EN to build the collision comparators; otherwise hit outputs are 0.
module obstacle_bank #(
  parameter int NUM_OBS      = 4,
  parameter int SIZE         = 16,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 479,
  parameter int STEP_W       = 4,
  parameter int DEFAULT_STEP = 1
) (
  input  logic                    frame_clk,
  input  logic                    Reset_n,
  input  logic                    freeze,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [3:0]              cfg_idx,
  input  logic                    cfg_en,
  input  logic [1:0]              cfg_mode,
  input  logic [9:0]              cfg_x,
  input  logic [9:0]              cfg_y,
  input  logic [STEP_W-1:0]       cfg_dx,
  input  logic [STEP_W-1:0]       cfg_dy,
  input  logic [9:0]              player_x,
  input  logic [9:0]              player_y,
  input  logic [9:0]              player_size,
  output logic [10*NUM_OBS-1:0]   obs_x,
  output logic [10*NUM_OBS-1:0]   obs_y,
  output logic [NUM_OBS-1:0]      obs_active,
  output logic [9:0]              OBS_size,
  output logic [NUM_OBS-1:0]      hit_vec,
  output logic                    hit_pulse,
  output logic [3:0]              hit_idx
);
  typedef enum logic [1:0] {STOP, BOUNCE, WRAP, PATROL_X} mode_e;
  localparam logic signed [11:0] SZ = 12'(SIZE);
  localparam logic signed [11:0] XL = 12'(X_MIN);
  localparam logic signed [11:0] XH = 12'(X_MAX);
  localparam logic signed [11:0] YL = 12'(Y_MIN);
  localparam logic signed [11:0] YH = 12'(Y_MAX);
  localparam logic [STEP_W-1:0] STEP_MIN = {1'b1, {(STEP_W-1){1'b0}}};
  // One axis of motion in 12-bit signed so edge overshoot never wraps; returns {pos, step}
  function automatic logic [STEP_W+9:0] move(input logic [9:0] p, input logic [STEP_W-1:0] d,
                                             input logic wrap, input logic signed [11:0] lo,
                                             input logic signed [11:0] hi);
    logic signed [11:0] n, r;
    logic [STEP_W-1:0] s;
    n = $signed({2'b00, p}) + $signed({{(12-STEP_W){d[STEP_W-1]}}, d});
    s = d;
    if (wrap) r = n > hi ? n - (hi - lo + 12'sd1) : n < lo ? n + (hi - lo + 12'sd1) : n;
    else if (n - SZ < lo) begin
      r = lo + SZ;
      s = -d;
    end else if (n + SZ > hi) begin
      r = hi - SZ;
      s = -d;
    end else r = n;
    return {10'(r), s};
  endfunction
  function automatic logic [9:0] clamp(input logic [9:0] v, input logic signed [11:0] lo,
                                       input logic signed [11:0] hi);
    logic signed [11:0] w;
    w = $signed({2'b00, v});
    return w < lo ? 10'(lo) : w > hi ? 10'(hi) : v;
  endfunction
  // The most negative step has no positive twin, so it is pulled in by one to keep negation exact
  function automatic logic [STEP_W-1:0] sat(input logic [STEP_W-1:0] d);
    return d == STEP_MIN ? STEP_MIN + 1'b1 : d;
  endfunction
  logic cfg_ready_q, acc;
  assign acc       = cfg_valid & cfg_ready_q;
  assign cfg_ready = cfg_ready_q;
  assign OBS_size  = 10'(SIZE);
  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) cfg_ready_q <= 1'b1;
    else cfg_ready_q <= ~acc;
`ifdef OBSTACLE_COLLIDE_EN
  logic [NUM_OBS-1:0] ovl, new_hit, hit_vec_q;
  logic               hit_pulse_q;
  logic [3:0]         hit_idx_q, hit_idx_d;
  logic [10:0]        reach;
  function automatic logic [10:0] adiff(input logic [9:0] a, input logic [9:0] b);
    return a >= b ? {1'b0, a - b} : {1'b0, b - a};
  endfunction
  assign reach = 11'(SIZE) + {1'b0, player_size};
`endif
  for (genvar i = 0; i < NUM_OBS; i++) begin : g_obs
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [STEP_W-1:0] dx_q, dx_d, dy_q, dy_d;
    mode_e             mode_q, mode_d;
    logic              act_q, act_d, wr;
    logic [STEP_W+9:0] nx, ny;
    assign wr = acc & (cfg_idx == 4'(i));
    assign nx = move(x_q, dx_q, mode_q == WRAP, XL, XH);
    assign ny = move(y_q, dy_q, mode_q == WRAP, YL, YH);
    always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      dx_d   = dx_q;
      dy_d   = dy_q;
      mode_d = mode_q;
      act_d  = act_q;
      if (wr) begin
        x_d    = clamp(cfg_x, XL + SZ, XH - SZ);
        y_d    = clamp(cfg_y, YL + SZ, YH - SZ);
        dx_d   = sat(cfg_dx);
        dy_d   = sat(cfg_dy);
        mode_d = mode_e'(cfg_mode);
        act_d  = cfg_en;
      end else if (act_q && !freeze && mode_q != STOP) begin
        {x_d, dx_d} = nx;
        if (mode_q != PATROL_X) {y_d, dy_d} = ny;
      end
    end
    always_ff @(posedge frame_clk or negedge Reset_n)
      if (!Reset_n) begin
        x_q    <= 10'(X_MIN + SIZE);
        y_q    <= 10'(Y_MIN + SIZE);
        dx_q   <= STEP_W'(DEFAULT_STEP);
        dy_q   <= '0;
        mode_q <= BOUNCE;
        act_q  <= 1'b0;
      end else begin
        x_q    <= x_d;
        y_q    <= y_d;
        dx_q   <= dx_d;
        dy_q   <= dy_d;
        mode_q <= mode_d;
        act_q  <= act_d;
      end
    assign obs_x[10*i +: 10] = x_q;
    assign obs_y[10*i +: 10] = y_q;
    assign obs_active[i]     = act_q;
`ifdef OBSTACLE_COLLIDE_EN
    assign ovl[i] = act_q && adiff(x_q, player_x) < reach && adiff(y_q, player_y) < reach;
`endif
  end
`ifdef OBSTACLE_COLLIDE_EN
  assign new_hit = ovl & ~hit_vec_q;
  always_comb begin
    hit_idx_d = '0;
    for (int k = NUM_OBS - 1; k >= 0; k--) hit_idx_d = new_hit[k] ? 4'(k) : hit_idx_d;
  end
  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) begin
      hit_vec_q   <= '0;
      hit_pulse_q <= 1'b0;
      hit_idx_q   <= '0;
    end else begin
      hit_vec_q   <= ovl;
      hit_pulse_q <= |new_hit;
      hit_idx_q   <= hit_idx_d;
    end
  assign hit_vec   = hit_vec_q;
  assign hit_pulse = hit_pulse_q;
  assign hit_idx   = hit_idx_q;
`else
  logic unused_player;
  assign unused_player = ^{player_x, player_y, player_size};
  assign hit_vec       = '0;
  assign hit_pulse     = 1'b0;
  assign hit_idx       = '0;
`endif
endmodule
